// File: rtl/lcis_engine.sv
// Longest monotonic run finder: streams an array from single-port RAM and writes back
// the length and start offset of the longest run under the selected ordering.
module lcis_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int SIGNED     = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  order_valid,
    input  logic [ADDR_WIDTH-1:0] order_start,
    input  logic [ADDR_WIDTH-1:0] order_len,
    input  logic [ADDR_WIDTH-1:0] order_back,
    input  logic [1:0]            order_mode,
    output logic                  order_busy,
    output logic                  order_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_write_req,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_WB_LEN = 3'd3;
    localparam logic [2:0] S_WB_IDX = 3'd4;

    localparam int EXT_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam bit IS_SIGNED = (SIGNED != 0);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] back_q, back_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [ADDR_WIDTH-1:0] cur_len_q, cur_len_d;
    logic [ADDR_WIDTH-1:0] cur_start_q, cur_start_d;
    logic [ADDR_WIDTH-1:0] best_len_q, best_len_d;
    logic [ADDR_WIDTH-1:0] best_start_q, best_start_d;
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_write_req_q, ram_write_req_d;
    logic [DATA_WIDTH-1:0] ram_write_data_q, ram_write_data_d;
    logic                  done_q, done_d;

    logic                  dat_vld;
    logic                  lt, eq, keep;
    logic [EXT_W-1:0]      len_ext, idx_ext;

    assign order_busy     = (state_q != S_IDLE);
    assign order_done     = done_q;
    assign ram_addr       = ram_addr_q;
    assign ram_write_req  = ram_write_req_q;
    assign ram_write_data = ram_write_data_q;

    // Bit k set means the address issued k+1 cycles ago is still in flight.
    assign dat_vld = vld_pipe_q[RD_LATENCY-1];

    always_comb begin
        lt = IS_SIGNED ? ($signed(prev_q) < $signed(ram_read_data)) : (prev_q < ram_read_data);
        eq = (prev_q == ram_read_data);
        case (mode_q)
            2'b00:   keep = lt;
            2'b01:   keep = lt | eq;
            2'b10:   keep = !lt && !eq;
            default: keep = !lt;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        start_d          = start_q;
        len_d            = len_q;
        back_d           = back_q;
        mode_d           = mode_q;
        cnt_d            = cnt_q;
        rx_d             = rx_q;
        prev_d           = prev_q;
        cur_len_d        = cur_len_q;
        cur_start_d      = cur_start_q;
        best_len_d       = best_len_q;
        best_start_d     = best_start_q;
        vld_pipe_d       = RD_LATENCY'({vld_pipe_q, (state_q == S_READ)});
        ram_addr_d       = '0;
        ram_write_req_d  = 1'b0;
        ram_write_data_d = ram_write_data_q;
        done_d           = 1'b0;

        if (dat_vld) begin
            prev_d = ram_read_data;
            rx_d   = rx_q + ADDR_WIDTH'(1);
            if (rx_q == '0 || !keep) begin
                cur_len_d   = ADDR_WIDTH'(1);
                cur_start_d = rx_q;
            end else begin
                cur_len_d   = cur_len_q + ADDR_WIDTH'(1);
            end
            // Strict compare keeps the earliest run when lengths tie.
            if (cur_len_d > best_len_q) begin
                best_len_d   = cur_len_d;
                best_start_d = cur_start_d;
            end
        end

        len_ext = EXT_W'(best_len_d);
        idx_ext = EXT_W'(best_start_q);

        case (state_q)
            S_IDLE: begin
                if (order_valid) begin
                    start_d      = order_start;
                    len_d        = order_len;
                    back_d       = order_back;
                    mode_d       = order_mode;
                    cnt_d        = ADDR_WIDTH'(1);
                    rx_d         = '0;
                    prev_d       = '0;
                    cur_len_d    = '0;
                    cur_start_d  = '0;
                    best_len_d   = '0;
                    best_start_d = '0;
                    if (order_len != '0) begin
                        state_d    = S_READ;
                        ram_addr_d = order_start;
                    end else begin
                        state_d          = S_WB_LEN;
                        ram_addr_d       = order_back;
                        ram_write_req_d  = 1'b1;
                        ram_write_data_d = '0;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end else begin
                    ram_addr_d = start_q + cnt_q;
                    cnt_d      = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // The final datum is folded in on the same edge that issues the length write.
                if (dat_vld && rx_q == len_q - ADDR_WIDTH'(1)) begin
                    state_d          = S_WB_LEN;
                    ram_addr_d       = back_q;
                    ram_write_req_d  = 1'b1;
                    ram_write_data_d = len_ext[DATA_WIDTH-1:0];
                end
            end
            S_WB_LEN: begin
                state_d          = S_WB_IDX;
                ram_addr_d       = back_q + ADDR_WIDTH'(1);
                ram_write_req_d  = 1'b1;
                ram_write_data_d = idx_ext[DATA_WIDTH-1:0];
            end
            S_WB_IDX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            start_q          <= '0;
            len_q            <= '0;
            back_q           <= '0;
            mode_q           <= '0;
            cnt_q            <= '0;
            rx_q             <= '0;
            prev_q           <= '0;
            cur_len_q        <= '0;
            cur_start_q      <= '0;
            best_len_q       <= '0;
            best_start_q     <= '0;
            vld_pipe_q       <= '0;
            ram_addr_q       <= '0;
            ram_write_req_q  <= 1'b0;
            ram_write_data_q <= '0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            start_q          <= start_d;
            len_q            <= len_d;
            back_q           <= back_d;
            mode_q           <= mode_d;
            cnt_q            <= cnt_d;
            rx_q             <= rx_d;
            prev_q           <= prev_d;
            cur_len_q        <= cur_len_d;
            cur_start_q      <= cur_start_d;
            best_len_q       <= best_len_d;
            best_start_q     <= best_start_d;
            vld_pipe_q       <= vld_pipe_d;
            ram_addr_q       <= ram_addr_d;
            ram_write_req_q  <= ram_write_req_d;
            ram_write_data_q <= ram_write_data_d;
            done_q           <= done_d;
        end
    end

endmodule
